// File: rtl/core_data_mem_ctrl_pkg.sv
// rtl/core_data_mem_ctrl_pkg.sv - shared types and constants for the data-memory controller
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
package core_data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_CNT_WIDTH = 4;
    localparam int NUM_LANES      = 4;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK_EN = 1'b1;
`else
    localparam bit ALIGN_CHECK_EN = 1'b0;
`endif

    // Full words must sit on a word boundary, half words on a half-word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [NUM_LANES-1:0] be);
        return ((be == 4'b1111) && (addr_lo != 2'b00)) ||
               (((be == 4'b0011) || (be == 4'b1100)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/core_data_mem_ctrl_if.sv
// rtl/core_data_mem_ctrl_if.sv - load/store request/response bus between core and data memory
interface core_data_mem_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
);
    logic                      req_i;
    logic                      we_i;
    logic [MEM_ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [3:0]                be_i;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      ack_o;
    logic                      err_o;
    logic                      busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  rdata_o, ack_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output rdata_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/core_data_mem_ctrl_ram.sv
// rtl/core_data_mem_ctrl_ram.sv - single-port byte-enabled RAM with registered read
module core_data_mem_ram
    import core_data_mem_ctrl_pkg::*;
#(
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en,
    input  logic                  we,
    input  logic [NUM_LANES-1:0]  be,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

    always_ff @(posedge clk_i) begin
        if (en && we) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                if (be[n]) begin
                    mem[idx][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

    // The read register doubles as the controller's rdata_o, so it only moves on loads.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/core_data_mem_ctrl.sv
// rtl/core_data_mem_ctrl.sv - wait-state data-memory responder; DMEM_ALIGN_CHECK_EN adds alignment errors
module core_data_mem_ctrl
    import core_data_mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_STATES    = 1
) (
    input  logic clk_i,
    input  logic rstn_i,
    core_data_mem_ctrl_if.slave bus
);
    localparam int IDX_WIDTH = MEM_ADDR_WIDTH - 2;
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_t                      state;
    logic [WAIT_CNT_WIDTH-1:0]   wait_cnt;
    logic                        lat_we;
    logic [MEM_ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]       lat_wdata;
    logic [NUM_LANES-1:0]        lat_be;
    logic                        ack_q;
    logic                        err_q;
    logic                        busy_q;

    logic                        cur_we;
    logic [MEM_ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]       cur_wdata;
    logic [NUM_LANES-1:0]        cur_be;
    logic                        misaligned;
    logic                        resp_entry;
    logic                        ram_en;

    // With zero wait states the RAM access happens on the accept edge itself,
    // so the live bus fields are used instead of the latched copy.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_be    = lat_be;
        if (state == ST_IDLE) begin
            cur_we    = bus.we_i;
            cur_addr  = bus.addr_i;
            cur_wdata = bus.wdata_i;
            cur_be    = bus.be_i;
        end
        misaligned = ALIGN_CHECK_EN && is_misaligned(cur_addr[1:0], cur_be);
        resp_entry = rstn_i &&
                     (((state == ST_IDLE) && bus.req_i && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == '0)));
        ram_en     = resp_entry && !(cur_we && misaligned);
    end

    core_data_mem_ram #(
        .IDX_WIDTH  (IDX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en     (ram_en),
        .we     (cur_we),
        .be     (cur_be),
        .idx    (cur_addr[MEM_ADDR_WIDTH-1:2]),
        .wdata  (cur_wdata),
        .rdata  (bus.rdata_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        lat_we    <= bus.we_i;
                        lat_addr  <= bus.addr_i;
                        lat_wdata <= bus.wdata_i;
                        lat_be    <= bus.be_i;
                        busy_q    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                            ack_q <= 1'b1;
                            err_q <= misaligned;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                        ack_q <= 1'b1;
                        err_q <= misaligned;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    ack_q  <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;
    assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_core_data_mem_ctrl.sv
// tb/tb_core_data_mem_ctrl.sv - scoreboard bench for two controllers (0 and 1 wait states)
module tb_core_data_mem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn0 = 1'b0;
    logic rstn1 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mdl [2][256];
    logic [31:0] last_rd [2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_data_mem_ctrl_if #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) b0();
    core_data_mem_ctrl_if #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) b1();

    core_data_mem_ctrl #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn0), .bus(b0));
    core_data_mem_ctrl #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(1)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn1), .bus(b1));

    function automatic logic ack_of(input int s);
        return (s == 0) ? b0.ack_o : b1.ack_o;
    endfunction
    function automatic logic busy_of(input int s);
        return (s == 0) ? b0.busy_o : b1.busy_o;
    endfunction
    function automatic logic err_of(input int s);
        return (s == 0) ? b0.err_o : b1.err_o;
    endfunction
    function automatic logic [31:0] rdata_of(input int s);
        return (s == 0) ? b0.rdata_o : b1.rdata_o;
    endfunction

    function automatic bit ref_misaligned(input logic [9:0] a, input logic [3:0] be);
        bit word_bad = (be == 4'hF) && (a % 4 != 0);
        bit half_bad = ((be == 4'h3) || (be == 4'hC)) && (a % 2 != 0);
        return word_bad || half_bad;
    endfunction

    task automatic drive(input int s, input logic r, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (s == 0) begin
            b0.req_i = r; b0.we_i = we; b0.addr_i = a; b0.wdata_i = d; b0.be_i = be;
        end else begin
            b1.req_i = r; b1.we_i = we; b1.addr_i = a; b1.wdata_i = d; b1.be_i = be;
        end
    endtask

    // Reference memory: word array indexed by address/4, lanes patched byte by byte.
    task automatic model_issue(input int s, input logic we, input logic [9:0] a,
                               input logic [31:0] d, input logic [3:0] be, input int acc);
        exp_t        e;
        logic [31:0] w;
        bit          mis;
        int          idx;
        idx = int'(a) / 4;
        mis = ALN && ref_misaligned(a, be);
        w   = mdl[s][idx];
        if (we) begin
            if (!mis) begin
                for (int n = 0; n < 4; n++) begin
                    if (be[n]) w[8*n +: 8] = d[8*n +: 8];
                end
                mdl[s][idx] = w;
            end
        end else begin
            last_rd[s] = w;
        end
        e.data = last_rd[s];
        e.err  = mis;
        e.cyc  = acc + s;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_resp(input int s);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (s == 0) begin
            if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        end else begin
            if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL resp_unexpected dut%0d: ack at cycle %0d with nothing outstanding", s, cyc);
        end else if (rdata_of(s) !== e.data || err_of(s) !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL resp dut%0d: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                     s, rdata_of(s), err_of(s), cyc, e.data, e.err, e.cyc);
        end
    endtask

    always begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            if (ack_of(s)) begin
                check_resp(s);
            end else begin
                checks++;
                if (err_of(s) !== 1'b0) begin
                    errors++;
                    $display("FAIL err_idle dut%0d: got %b required 0 at cycle %0d", s, err_of(s), cyc);
                end
            end
        end
    end

    task automatic xfer(input int s, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        bit seen;
        seen = 1'b0;
        drive(s, 1'b1, we, a, d, be);
        @(posedge clk); #1;
        model_issue(s, we, a, d, be, cyc);
        drive(s, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            checks++;
            if (busy_of(s) !== 1'b1) begin
                errors++;
                $display("FAIL busy dut%0d: got %b required 1 at cycle %0d", s, busy_of(s), cyc);
            end
            if (ack_of(s)) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack, required one within 20 cycles", s);
        end
        @(negedge clk);
        checks++;
        if (ack_of(s) !== 1'b0 || busy_of(s) !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_ack dut%0d: got ack=%b busy=%b required 0 0", s, ack_of(s), busy_of(s));
        end
    endtask

    task automatic check_idle_reset(input int s);
        checks++;
        if (ack_of(s) !== 1'b0 || busy_of(s) !== 1'b0 || err_of(s) !== 1'b0 || rdata_of(s) !== 32'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got ack=%b busy=%b err=%b rdata=%h required 0 0 0 00000000",
                     s, ack_of(s), busy_of(s), err_of(s), rdata_of(s));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] be_pick [6];
        logic [3:0] be;
        be_pick[0] = 4'hF; be_pick[1] = 4'h3; be_pick[2] = 4'hC;
        be_pick[3] = 4'h1; be_pick[4] = 4'h0; be_pick[5] = 4'h8;

        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn0 = 1'b1;
        rstn1 = 1'b1;
        @(negedge clk);
        check_idle_reset(0);
        check_idle_reset(1);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) xfer(s, 1'b1, 10'(i * 4), $urandom, 4'hF);
        end

        xfer(1, 1'b0, 10'h000, '0, 4'hF);
        xfer(1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        xfer(1, 1'b0, 10'h010, '0, 4'hF);
        xfer(1, 1'b1, 10'h011, 32'h000000AA, 4'b0001);
        xfer(1, 1'b0, 10'h010, '0, 4'hF);
        xfer(1, 1'b1, 10'h010, 32'h11223344, 4'b0000);
        xfer(1, 1'b0, 10'h010, '0, 4'hF);

        // Reset lands on the edge that would have entered RESP: store must vanish.
        drive(1, 1'b1, 1'b1, 10'h020, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        rstn1 = 1'b0;
        @(posedge clk); #1;
        rstn1 = 1'b1;
        last_rd[1] = '0;
        @(negedge clk);
        check_idle_reset(1);
        xfer(1, 1'b0, 10'h020, '0, 4'hF);

        xfer(1, 1'b1, 10'h022, 32'h55AA55AA, 4'hF);
        xfer(1, 1'b0, 10'h020, '0, 4'hF);
        xfer(1, 1'b1, 10'h022, 32'hBEEF0000, 4'b1100);
        xfer(1, 1'b0, 10'h020, '0, 4'hF);
        xfer(1, 1'b0, 10'h021, '0, 4'hF);
        xfer(1, 1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 10'h3FC, '0, 4'hF);

        // Zero wait states with req held: accepts on alternate edges only.
        drive(0, 1'b1, 1'b0, 10'h010, '0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0) model_issue(0, 1'b0, 10'h010, '0, 4'hF, cyc);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 120; i++) begin
            be = be_pick[$urandom_range(5, 0)];
            xfer(i % 2, 1'($urandom_range(1, 0)), 10'($urandom), $urandom, be);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d/%0d unanswered requests, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
